// File: rtl/axis_pkt_gen_core.sv
// Packet engine for the AXIS traffic generator: builds one descriptor (channel, length, pause)
// per packet from the register-block config and streams the payload on an AXI4-Stream master.
module axis_pkt_gen_core #(
  parameter int          DATA_WIDTH  = 32,
  parameter int          ID_WIDTH    = 10,
  parameter int          LEN_WIDTH   = 16,
  parameter int          PAUSE_WIDTH = 32,
  parameter logic [31:0] LFSR_SEED   = 32'hACE1_2468,
  localparam int         BYTES       = DATA_WIDTH / 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_start_i,
  input  logic                   cfg_stop_i,
  input  logic                   cfg_len_mode_i,
  input  logic [1:0]             cfg_ch_mode_i,
  input  logic                   cfg_pause_mode_i,
  input  logic [1:0]             cfg_data_mode_i,
  input  logic [LEN_WIDTH-1:0]   cfg_fix_len_i,
  input  logic [LEN_WIDTH-1:0]   cfg_min_len_i,
  input  logic [LEN_WIDTH-1:0]   cfg_max_len_i,
  input  logic [ID_WIDTH-1:0]    cfg_fix_ch_i,
  input  logic [ID_WIDTH-1:0]    cfg_min_ch_i,
  input  logic [ID_WIDTH-1:0]    cfg_max_ch_i,
  input  logic [PAUSE_WIDTH-1:0] cfg_fix_pause_i,
  input  logic [PAUSE_WIDTH-1:0] cfg_min_pause_i,
  input  logic [PAUSE_WIDTH-1:0] cfg_max_pause_i,
  input  logic [31:0]            cfg_pattern_i,
  input  logic [31:0]            cfg_pkt_limit_i,
  output logic [ID_WIDTH-1:0]    m_axis_tid_o,
  output logic [DATA_WIDTH-1:0]  m_axis_tdata_o,
  output logic                   m_axis_tvalid_o,
  output logic                   m_axis_tlast_o,
  output logic [BYTES-1:0]       m_axis_tkeep_o,
  input  logic                   m_axis_tready_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [31:0]            stat_pkts_o,
  output logic [47:0]            stat_bytes_o,
  output logic [1:0]             dbg_state_o
);

  // AXIS master: once tvalid rises, tid/tdata/tkeep/tlast hold until a cycle with
  // tvalid & tready; every piece of state here advances only on that handshake.
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DATA, S_PAUSE} state_t;

  state_t                 state_q, state_d;
  logic [31:0]            lfsr_q, lfsr_d;
  logic [ID_WIDTH-1:0]    ptr_q, ptr_d, ch_q, ch_d;
  logic [LEN_WIDTH-1:0]   rem_q, rem_d;
  logic [7:0]             off_q, off_d;
  logic [PAUSE_WIDTH-1:0] pause_q, pause_d, cnt_q, cnt_d;
  logic [1:0]             dmode_q, dmode_d;
  logic [31:0]            pattern_q, pattern_d, limit_q, limit_d, pkts_q, pkts_d;
  logic [47:0]            bytes_q, bytes_d;
  logic                   stop_pend_q, stop_pend_d, done_q, done_d;

  logic                   fire, is_last, stop_now;
  logic [LEN_WIDTH-1:0]   beat_bytes, len_sel;
  logic [ID_WIDTH-1:0]    ch_rr, ch_sel;
  logic [PAUSE_WIDTH-1:0] pause_sel;
  logic [BYTES-1:0]       keep_c;
  logic [DATA_WIDTH-1:0]  data_c;
  logic [7:0]             byte_c;

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  // Degenerate window (min > max) collapses to max.
  function automatic logic [LEN_WIDTH-1:0] clamp_len(input logic [LEN_WIDTH-1:0] v, lo, hi);
    if (lo > hi) return hi;
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic logic [ID_WIDTH-1:0] clamp_ch(input logic [ID_WIDTH-1:0] v, lo, hi);
    if (lo > hi) return hi;
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic logic [PAUSE_WIDTH-1:0] clamp_pause(input logic [PAUSE_WIDTH-1:0] v, lo, hi);
    if (lo > hi) return hi;
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  assign fire       = m_axis_tvalid_o && m_axis_tready_i;
  assign is_last    = rem_q <= LEN_WIDTH'(BYTES);
  assign beat_bytes = is_last ? rem_q : LEN_WIDTH'(BYTES);
  assign stop_now   = stop_pend_q || cfg_stop_i;

  // Pointer resets to 0; an out-of-range pointer maps to min, so the first rr packet uses min.
  assign ch_rr = (ptr_q < cfg_min_ch_i || ptr_q > cfg_max_ch_i) ? cfg_min_ch_i : ptr_q;

  always_comb begin
    len_sel   = cfg_len_mode_i ? clamp_len(LEN_WIDTH'(lfsr_q), cfg_min_len_i, cfg_max_len_i)
                               : cfg_fix_len_i;
    pause_sel = cfg_pause_mode_i
              ? clamp_pause(PAUSE_WIDTH'({lfsr_q[7:0], lfsr_q[31:8]}), cfg_min_pause_i, cfg_max_pause_i)
              : cfg_fix_pause_i;
    case (cfg_ch_mode_i)
      2'd0:    ch_sel = cfg_fix_ch_i;
      2'd1:    ch_sel = ch_rr;
      2'd2:    ch_sel = clamp_ch(ID_WIDTH'({lfsr_q[15:0], lfsr_q[31:16]}), cfg_min_ch_i, cfg_max_ch_i);
      default: ch_sel = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    ptr_d       = ptr_q;
    ch_d        = ch_q;
    rem_d       = rem_q;
    off_d       = off_q;
    pause_d     = pause_q;
    cnt_d       = cnt_q;
    dmode_d     = dmode_q;
    pattern_d   = pattern_q;
    limit_d     = limit_q;
    pkts_d      = pkts_q;
    bytes_d     = bytes_q;
    stop_pend_d = stop_pend_q || (cfg_stop_i && state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (cfg_start_i) begin
          state_d     = S_LOAD;
          pkts_d      = '0;
          bytes_d     = '0;
          stop_pend_d = 1'b0;
        end
      end
      // The LFSR is sampled for the random fields and then stepped once per descriptor.
      S_LOAD: begin
        state_d   = S_DATA;
        rem_d     = (len_sel == '0) ? LEN_WIDTH'(1) : len_sel;
        off_d     = '0;
        ch_d      = ch_sel;
        pause_d   = pause_sel;
        dmode_d   = cfg_data_mode_i;
        pattern_d = cfg_pattern_i;
        limit_d   = cfg_pkt_limit_i;
        lfsr_d    = lfsr_step(lfsr_q);
        if (cfg_ch_mode_i == 2'd1) ptr_d = (ch_rr >= cfg_max_ch_i) ? cfg_min_ch_i : ch_rr + 1'b1;
      end
      S_DATA: begin
        if (fire) begin
          rem_d   = rem_q - beat_bytes;
          off_d   = off_q + 8'(BYTES);
          bytes_d = bytes_q + 48'(beat_bytes);
          if (dmode_q == 2'd1) lfsr_d = lfsr_step(lfsr_q);
          if (is_last) begin
            pkts_d = pkts_q + 32'd1;
            if (stop_now || (limit_q != '0 && pkts_q + 32'd1 == limit_q)) state_d = S_IDLE;
            else if (pause_q == '0)                                       state_d = S_LOAD;
            else begin
              state_d = S_PAUSE;
              cnt_d   = pause_q;
            end
          end
        end
      end
      S_PAUSE: begin
        if (stop_now)                        state_d = S_IDLE;
        else if (cnt_q <= PAUSE_WIDTH'(1))   state_d = S_LOAD;
        else                                 cnt_d   = cnt_q - 1'b1;
      end
    endcase
    done_d = (state_q != S_IDLE) && (state_d == S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      lfsr_q      <= LFSR_SEED;
      ptr_q       <= '0;
      ch_q        <= '0;
      rem_q       <= '0;
      off_q       <= '0;
      pause_q     <= '0;
      cnt_q       <= '0;
      dmode_q     <= '0;
      pattern_q   <= '0;
      limit_q     <= '0;
      pkts_q      <= '0;
      bytes_q     <= '0;
      stop_pend_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      ptr_q       <= ptr_d;
      ch_q        <= ch_d;
      rem_q       <= rem_d;
      off_q       <= off_d;
      pause_q     <= pause_d;
      cnt_q       <= cnt_d;
      dmode_q     <= dmode_d;
      pattern_q   <= pattern_d;
      limit_q     <= limit_d;
      pkts_q      <= pkts_d;
      bytes_q     <= bytes_d;
      stop_pend_q <= stop_pend_d;
      done_q      <= done_d;
    end
  end

  // Payload byte i of the current beat; 32-bit sources repeat every four bytes.
  always_comb begin
    keep_c = '0;
    data_c = '0;
    byte_c = '0;
    for (int i = 0; i < BYTES; i++) begin
      keep_c[i] = !is_last || (rem_q > LEN_WIDTH'(i));
      case (dmode_q)
        2'd0:    byte_c = off_q + 8'(i);
        2'd1:    byte_c = 8'(lfsr_q >> (8 * (i % 4)));
        2'd2:    byte_c = 8'(pattern_q >> (8 * (i % 4)));
        default: byte_c = '0;
      endcase
      data_c[8*i +: 8] = byte_c;
    end
  end

  assign m_axis_tvalid_o = (state_q == S_DATA);
  assign m_axis_tid_o    = m_axis_tvalid_o ? ch_q : '0;
  assign m_axis_tdata_o  = m_axis_tvalid_o ? data_c : '0;
  assign m_axis_tkeep_o  = m_axis_tvalid_o ? keep_c : '0;
  assign m_axis_tlast_o  = m_axis_tvalid_o && is_last;
  assign busy_o          = (state_q != S_IDLE);
  assign done_o          = done_q;
  assign stat_pkts_o     = pkts_q;
  assign stat_bytes_o    = bytes_q;
  assign dbg_state_o     = state_q;

endmodule
